// File: rtl/dpmem_burst_reader_pkg.sv
// Shared defaults and FSM state encoding for the dual-port memory burst reader.
package dpmem_burst_reader_pkg;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ADD_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } dpmem_state_e;
endpackage

// File: rtl/dpmem_skid2.sv
// Two-entry FIFO that holds words returned by the memory until the consumer accepts them.
module dpmem_skid2
  import dpmem_burst_reader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Wr,
  input  logic [WIDTH-1:0] Wdata,
  input  logic             Pop,
  output logic [1:0]       Count,
  output logic [WIDTH-1:0] Rdata
);
  logic [WIDTH-1:0] mem [2];
  logic             wptr;
  logic             rptr;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      Count  <= 2'd0;
    end else begin
      if (Wr) begin
        mem[wptr] <= Wdata;
        wptr      <= ~wptr;
      end
      if (Pop) rptr <= ~rptr;
      case ({Wr, Pop})
        2'b10:   Count <= Count + 2'd1;
        2'b01:   Count <= Count - 2'd1;
        default: Count <= Count;
      endcase
    end
  end

  assign Rdata = mem[rptr];
endmodule

// File: rtl/dpmem_burst_reader.sv
// Reads a burst of Len words from a registered-output memory and streams them out
// with valid/ready flow control, never letting more than two words be in flight.
module dpmem_burst_reader
  import dpmem_burst_reader_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADD_WIDTH = DEF_ADD_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [ADD_WIDTH-1:0] StartAdd,
  input  logic [ADD_WIDTH:0]   Len,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Ren,
  output logic [ADD_WIDTH-1:0] Radd,
  input  logic [WIDTH-1:0]     Memout,
  output logic [WIDTH-1:0]     Dataout,
  output logic                 Dvalid,
  input  logic                 Dready,
  output dpmem_state_e         State
);
  dpmem_state_e         state;
  dpmem_state_e         state_nxt;
  logic [ADD_WIDTH-1:0] add_cnt;
  logic [ADD_WIDTH:0]   rem_cnt;
  logic                 pend;
  logic [1:0]           buf_cnt;
  logic [WIDTH-1:0]     buf_data;
  logic [2:0]           outst;
  logic                 start_ok;
  logic                 pop;
  logic                 buf_wr;
  logic                 buf_pop;

  // Stream handshake: a word moves when Dvalid && Dready in the same cycle;
  // Dvalid never depends on Dready and Dataout holds while Dvalid && !Dready.
  assign start_ok = (state == ST_IDLE) && Start && (Len != '0);
  assign outst    = {1'b0, buf_cnt} + {2'b00, pend};
  assign Dvalid   = (outst != 3'd0);
  // The word arriving on Memout is presented directly when the buffer is empty,
  // which gives the two-cycle Start-to-Dvalid latency.
  assign Dataout  = (buf_cnt != 2'd0) ? buf_data : (pend ? Memout : '0);
  assign pop      = Dvalid && Dready;
  assign buf_wr   = pend && !((buf_cnt == 2'd0) && pop);
  assign buf_pop  = pop && (buf_cnt != 2'd0);
  assign Busy     = (state != ST_IDLE);
  assign Radd     = add_cnt;
  assign State    = state;

  always_comb begin
    state_nxt = state;
    Ren       = 1'b0;
    Done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (outst < 3'd2) begin
          Ren = 1'b1;
          if (rem_cnt == (ADD_WIDTH+1)'(1)) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && (outst == 3'd1)) begin
          Done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= ST_IDLE;
      add_cnt <= '0;
      rem_cnt <= '0;
      pend    <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= Ren;
      if (start_ok) begin
        add_cnt <= StartAdd;
        rem_cnt <= Len;
      end else if (Ren) begin
        add_cnt <= add_cnt + ADD_WIDTH'(1);
        rem_cnt <= rem_cnt - (ADD_WIDTH+1)'(1);
      end
    end
  end

  dpmem_skid2 #(.WIDTH(WIDTH)) u_skid (
    .Clk   (Clk),
    .Rst   (Rst),
    .Wr    (buf_wr),
    .Wdata (Memout),
    .Pop   (buf_pop),
    .Count (buf_cnt),
    .Rdata (buf_data)
  );
endmodule
